// File: rtl/arbiter_pkg.sv
// ----------------------------------------------------------------------------
// arbiter_pkg
// Shared definitions for the L2 round-robin arbiter:
//   - arb_state_t    : arbiter FSM states (IDLE / BUSY / DONE)
//   - ARB_ADDR_WIDTH : default byte address width
//   - ARB_LINE_WIDTH : default cache line width
//   - idx_width()    : width of a port index for a given port count
// ----------------------------------------------------------------------------
package arbiter_pkg;

    localparam int ARB_ADDR_WIDTH = 16;
    localparam int ARB_LINE_WIDTH = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // A single-port build still needs a 1-bit index to keep vectors legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_rr_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational rotating-priority selector. Returns the first active port at
// or after i_rr_ptr, wrapping modulo NUM_PORTS.
// Ports:
//   i_active  [NUM_PORTS]  per-port request-active vector
//   i_rr_ptr  [IDX_W]      highest-priority port this round
//   o_found   1            at least one port is active
//   o_grant   [IDX_W]      selected port index (0 when none found)
// ----------------------------------------------------------------------------
module rr_picker
    import arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_active,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic                 o_found,
    output logic [IDX_W-1:0]     o_grant
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_sum;

    // Scan offsets from farthest to nearest so the nearest active port
    // (lowest offset from the pointer) is the last one to overwrite.
    always_comb begin
        o_found = 1'b0;
        o_grant = '0;
        w_sum   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_rr_ptr} + SUM_W'(i);
            if (w_sum >= SUM_W'(NUM_PORTS)) begin
                w_sum = w_sum - SUM_W'(NUM_PORTS);
            end
            if (i_active[w_sum[IDX_W-1:0]]) begin
                o_found = 1'b1;
                o_grant = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/l2_rr_arbiter.sv
// ----------------------------------------------------------------------------
// l2_rr_arbiter
// Round-robin arbiter multiplexing NUM_PORTS L1 miss/writeback channels onto
// one L2 line interface. One L2 transaction at a time; all L2-side and
// response outputs are registered.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_read/req_write  per-port line read/write request (held until resp)
//   req_addr/req_wdata  per-port address / write line, port p at slice p
//   req_rdata           read line, valid in the req_resp cycle
//   req_resp            one-hot completion pulse
//   L2_read/L2_write    strobes toward L2, held through the transaction
//   L2_addr/L2_wdata    captured address / write line
//   L2_rdata/L2_resp    L2 read line and one-cycle completion
// ----------------------------------------------------------------------------
module l2_rr_arbiter
    import arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int LINE_WIDTH = ARB_LINE_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic                             L2_read,
    output logic                             L2_write,
    output logic [ADDR_WIDTH-1:0]            L2_addr,
    output logic [LINE_WIDTH-1:0]            L2_wdata,
    input  logic [LINE_WIDTH-1:0]            L2_rdata,
    input  logic                             L2_resp
);

    localparam int IDX_W = idx_width(NUM_PORTS);

    arb_state_t              r_state,     w_state_nxt;
    logic [IDX_W-1:0]        r_rr_ptr,    w_rr_ptr_nxt;
    logic [IDX_W-1:0]        r_grant_idx, w_grant_idx_nxt;
    logic                    r_l2_read,   w_l2_read_nxt;
    logic                    r_l2_write,  w_l2_write_nxt;
    logic [ADDR_WIDTH-1:0]   r_l2_addr,   w_l2_addr_nxt;
    logic [LINE_WIDTH-1:0]   r_l2_wdata,  w_l2_wdata_nxt;
    logic [LINE_WIDTH-1:0]   r_rdata,     w_rdata_nxt;
    logic [NUM_PORTS-1:0]    r_resp,      w_resp_nxt;

    logic [NUM_PORTS-1:0]    w_active;
    logic                    w_found;
    logic [IDX_W-1:0]        w_pick;
    logic [ADDR_WIDTH-1:0]   w_addr_arr  [NUM_PORTS];
    logic [LINE_WIDTH-1:0]   w_wdata_arr [NUM_PORTS];

    assign w_active = req_read | req_write;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[g] = req_wdata[g*LINE_WIDTH +: LINE_WIDTH];
    end

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .i_active  (w_active),
        .i_rr_ptr  (r_rr_ptr),
        .o_found   (w_found),
        .o_grant   (w_pick)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_idx_nxt = r_grant_idx;
        w_l2_read_nxt   = r_l2_read;
        w_l2_write_nxt  = r_l2_write;
        w_l2_addr_nxt   = r_l2_addr;
        w_l2_wdata_nxt  = r_l2_wdata;
        w_rdata_nxt     = r_rdata;
        w_resp_nxt      = r_resp;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    // A port asserting both read and write is serviced as a write.
                    w_l2_write_nxt  = req_write[w_pick];
                    w_l2_read_nxt   = ~req_write[w_pick];
                    w_l2_addr_nxt   = w_addr_arr[w_pick];
                    w_l2_wdata_nxt  = w_wdata_arr[w_pick];
                    w_grant_idx_nxt = w_pick;
                    w_state_nxt     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (L2_resp) begin
                    w_rdata_nxt                = L2_rdata;
                    w_rr_ptr_nxt               = (r_grant_idx == IDX_W'(NUM_PORTS - 1))
                                                 ? '0 : r_grant_idx + 1'b1;
                    w_l2_read_nxt              = 1'b0;
                    w_l2_write_nxt             = 1'b0;
                    w_resp_nxt                 = '0;
                    w_resp_nxt[r_grant_idx]    = 1'b1;
                    w_state_nxt                = ST_DONE;
                end
            end
            ST_DONE: begin
                // One-cycle gap lets the served port drop its request before
                // the next arbitration.
                w_resp_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_l2_read   <= 1'b0;
            r_l2_write  <= 1'b0;
            r_l2_addr   <= '0;
            r_l2_wdata  <= '0;
            r_rdata     <= '0;
            r_resp      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_l2_read   <= w_l2_read_nxt;
            r_l2_write  <= w_l2_write_nxt;
            r_l2_addr   <= w_l2_addr_nxt;
            r_l2_wdata  <= w_l2_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_resp      <= w_resp_nxt;
        end
    end

    assign L2_read   = r_l2_read;
    assign L2_write  = r_l2_write;
    assign L2_addr   = r_l2_addr;
    assign L2_wdata  = r_l2_wdata;
    assign req_rdata = r_rdata;
    assign req_resp  = r_resp;

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// Bench for l2_rr_arbiter: a 2-port instance (index 0) and a 4-port instance
// (index 1) share clock and reset. A transaction-level model predicts every
// output each cycle; directed scenarios add literal expectations.
module tb_l2_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester-side stimulus, [instance][port]
    logic         tb_rd    [2][4];
    logic         tb_wr    [2][4];
    logic [15:0]  tb_addr  [2][4];
    logic [127:0] tb_wdata [2][4];
    bit           refill      [2][4];
    bit           refill_pend [2][4];

    // L2 responder per instance
    logic         l2_resp [2];
    logic [127:0] l2_pat  [2];
    int           lat     [2];
    int           rcnt    [2];

    // 2-port instance
    logic [1:0]   d2_rd, d2_wr, d2_resp;
    logic [31:0]  d2_addr_in;
    logic [255:0] d2_wd_in;
    logic [127:0] d2_rdata, d2_l2wd;
    logic         d2_l2r, d2_l2w;
    logic [15:0]  d2_l2a;

    assign d2_rd      = {tb_rd[0][1], tb_rd[0][0]};
    assign d2_wr      = {tb_wr[0][1], tb_wr[0][0]};
    assign d2_addr_in = {tb_addr[0][1], tb_addr[0][0]};
    assign d2_wd_in   = {tb_wdata[0][1], tb_wdata[0][0]};

    l2_rr_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .req_read  (d2_rd),
        .req_write (d2_wr),
        .req_addr  (d2_addr_in),
        .req_wdata (d2_wd_in),
        .req_rdata (d2_rdata),
        .req_resp  (d2_resp),
        .L2_read   (d2_l2r),
        .L2_write  (d2_l2w),
        .L2_addr   (d2_l2a),
        .L2_wdata  (d2_l2wd),
        .L2_rdata  (l2_pat[0]),
        .L2_resp   (l2_resp[0])
    );

    // 4-port instance
    logic [3:0]   d4_rd, d4_wr, d4_resp;
    logic [63:0]  d4_addr_in;
    logic [511:0] d4_wd_in;
    logic [127:0] d4_rdata, d4_l2wd;
    logic         d4_l2r, d4_l2w;
    logic [15:0]  d4_l2a;

    assign d4_rd      = {tb_rd[1][3], tb_rd[1][2], tb_rd[1][1], tb_rd[1][0]};
    assign d4_wr      = {tb_wr[1][3], tb_wr[1][2], tb_wr[1][1], tb_wr[1][0]};
    assign d4_addr_in = {tb_addr[1][3], tb_addr[1][2], tb_addr[1][1], tb_addr[1][0]};
    assign d4_wd_in   = {tb_wdata[1][3], tb_wdata[1][2], tb_wdata[1][1], tb_wdata[1][0]};

    l2_rr_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .req_read  (d4_rd),
        .req_write (d4_wr),
        .req_addr  (d4_addr_in),
        .req_wdata (d4_wd_in),
        .req_rdata (d4_rdata),
        .req_resp  (d4_resp),
        .L2_read   (d4_l2r),
        .L2_write  (d4_l2w),
        .L2_addr   (d4_l2a),
        .L2_wdata  (d4_l2wd),
        .L2_rdata  (l2_pat[1]),
        .L2_resp   (l2_resp[1])
    );

    // Uniform views of both instances
    logic         dut_l2r  [2];
    logic         dut_l2w  [2];
    logic [15:0]  dut_l2a  [2];
    logic [127:0] dut_l2wd [2];
    logic [127:0] dut_rdata[2];
    logic [3:0]   dut_resp [2];

    assign dut_l2r[0]   = d2_l2r;
    assign dut_l2r[1]   = d4_l2r;
    assign dut_l2w[0]   = d2_l2w;
    assign dut_l2w[1]   = d4_l2w;
    assign dut_l2a[0]   = d2_l2a;
    assign dut_l2a[1]   = d4_l2a;
    assign dut_l2wd[0]  = d2_l2wd;
    assign dut_l2wd[1]  = d4_l2wd;
    assign dut_rdata[0] = d2_rdata;
    assign dut_rdata[1] = d4_rdata;
    assign dut_resp[0]  = {2'b00, d2_resp};
    assign dut_resp[1]  = d4_resp;

    // ------------------------------------------------------------------
    // Transaction-level model: phase 0 = free, 1 = L2 in flight,
    // 2 = completion being reported.
    // ------------------------------------------------------------------
    int           m_phase [2];
    int           m_ptr   [2];
    int           m_grant [2];
    logic         m_read  [2];
    logic         m_write [2];
    logic [15:0]  m_addr  [2];
    logic [127:0] m_wdata [2];
    logic [127:0] m_rdata [2];
    logic [3:0]   m_resp  [2];

    function automatic int nports(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int pick(input int d);
        int n;
        int p;
        n = nports(d);
        for (int i = 0; i < n; i++) begin
            p = (m_ptr[d] + i) % n;
            if (tb_rd[d][p] || tb_wr[d][p]) return p;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_phase[d] <= 0;
                m_ptr[d]   <= 0;
                m_grant[d] <= 0;
                m_read[d]  <= 1'b0;
                m_write[d] <= 1'b0;
                m_addr[d]  <= '0;
                m_wdata[d] <= '0;
                m_rdata[d] <= '0;
                m_resp[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_phase[d] == 0) begin
                    if (pick(d) >= 0) begin
                        m_write[d] <= tb_wr[d][pick(d)];
                        m_read[d]  <= !tb_wr[d][pick(d)];
                        m_addr[d]  <= tb_addr[d][pick(d)];
                        m_wdata[d] <= tb_wdata[d][pick(d)];
                        m_grant[d] <= pick(d);
                        m_phase[d] <= 1;
                    end
                end else if (m_phase[d] == 1) begin
                    if (l2_resp[d]) begin
                        m_rdata[d] <= l2_pat[d];
                        m_ptr[d]   <= (m_grant[d] + 1) % nports(d);
                        m_read[d]  <= 1'b0;
                        m_write[d] <= 1'b0;
                        m_resp[d]  <= 4'(1 << m_grant[d]);
                        m_phase[d] <= 2;
                    end
                end else begin
                    m_resp[d]  <= '0;
                    m_phase[d] <= 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int           rq0[$];
    int           rq1[$];
    logic [127:0] wq1[$];
    bit           prev_stb[2];

    int exp2[5] = '{0, 1, 0, 1, 0};
    int exp4[5] = '{0, 1, 2, 3, 0};
    logic [127:0] lines[4] = '{128'h0000_1111_0000_1111_0000_1111_0000_1111,
                               128'h2222_AAAA_2222_AAAA_2222_AAAA_2222_AAAA,
                               128'h3333_5555_3333_5555_3333_5555_3333_5555,
                               128'h4444_CCCC_4444_CCCC_4444_CCCC_4444_CCCC};
    logic [127:0] expw4[5] = '{128'h0000_1111_0000_1111_0000_1111_0000_1111,
                               128'h2222_AAAA_2222_AAAA_2222_AAAA_2222_AAAA,
                               128'h3333_5555_3333_5555_3333_5555_3333_5555,
                               128'h4444_CCCC_4444_CCCC_4444_CCCC_4444_CCCC,
                               128'h0000_1111_0000_1111_0000_1111_0000_1111};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        bit stb;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d L2_read", d),  dut_l2r[d],  m_read[d]);
            chk($sformatf("d%0d L2_write", d), dut_l2w[d],  m_write[d]);
            chk($sformatf("d%0d L2_addr", d),  dut_l2a[d],  m_addr[d]);
            chk($sformatf("d%0d L2_wdata", d), dut_l2wd[d], m_wdata[d]);
            chk($sformatf("d%0d req_resp", d), dut_resp[d], m_resp[d]);
            if (m_resp[d] != 0)
                chk($sformatf("d%0d req_rdata", d), dut_rdata[d], m_rdata[d]);
            for (int p = 0; p < nports(d); p++) begin
                if (dut_resp[d][p]) begin
                    if (d == 0) rq0.push_back(p);
                    else        rq1.push_back(p);
                end
            end
            stb = dut_l2r[d] | dut_l2w[d];
            if (d == 1 && stb && !prev_stb[1]) wq1.push_back(dut_l2wd[1]);
            prev_stb[d] = stb;
        end
    endtask

    // Requester and L2 responder behaviour, applied on the falling edge.
    task automatic house();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                l2_resp[d] = 1'b0;
                rcnt[d]    = 0;
            end else if (l2_resp[d]) begin
                l2_resp[d] = 1'b0;
                rcnt[d]    = 0;
            end else if (dut_l2r[d] | dut_l2w[d]) begin
                rcnt[d]++;
                if (rcnt[d] > lat[d]) l2_resp[d] = 1'b1;
            end
            for (int p = 0; p < nports(d); p++) begin
                if (refill_pend[d][p]) begin
                    tb_wr[d][p]       = 1'b1;
                    refill_pend[d][p] = 1'b0;
                end
                if (dut_resp[d][p]) begin
                    tb_rd[d][p] = 1'b0;
                    tb_wr[d][p] = 1'b0;
                    if (refill[d][p]) refill_pend[d][p] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        house();
    endtask

    function automatic bit any_req(input int d);
        for (int p = 0; p < nports(d); p++)
            if (tb_rd[d][p] || tb_wr[d][p] || refill_pend[d][p]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle(input int d, input int maxc);
        bit done;
        done = 1'b0;
        for (int c = 0; c < maxc && !done; c++) begin
            tick();
            done = !any_req(d) && (m_phase[d] == 0) && !dut_l2r[d] && !dut_l2w[d]
                   && (dut_resp[d] == 0);
        end
        chk($sformatf("d%0d idle within budget", d), done, 1'b1);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 4; p++) begin
                tb_rd[d][p] = 1'b0;
                tb_wr[d][p] = 1'b0;
                tb_addr[d][p] = '0;
                tb_wdata[d][p] = '0;
                refill[d][p] = 1'b0;
                refill_pend[d][p] = 1'b0;
            end
            l2_resp[d] = 1'b0;
            l2_pat[d]  = '0;
            lat[d]     = 1;
            rcnt[d]    = 0;
            prev_stb[d] = 1'b0;
        end

        // Reset state
        tick();
        tick();
        chk("reset d2 L2_read",   d2_l2r,   1'b0);
        chk("reset d2 L2_write",  d2_l2w,   1'b0);
        chk("reset d2 L2_addr",   d2_l2a,   16'h0);
        chk("reset d2 req_resp",  d2_resp,  2'b00);
        chk("reset d2 req_rdata", d2_rdata, 128'h0);
        chk("reset d4 L2_wdata",  d4_l2wd,  128'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("idle no strobe", d2_l2r | d2_l2w | d4_l2r | d4_l2w, 1'b0);

        // Single read on port 0, L2 answers three cycles after the strobe rises
        lat[0]       = 3;
        l2_pat[0]    = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
        tb_addr[0][0] = 16'h1230;
        tb_rd[0][0]   = 1'b1;
        tick();
        chk("single read strobe c1", d2_l2r, 1'b1);
        chk("single read addr c1",   d2_l2a, 16'h1230);
        chk("single read no write",  d2_l2w, 1'b0);
        tick();
        tick();
        tick();
        chk("single read strobe c4", d2_l2r, 1'b1);
        chk("single read no resp c4", d2_resp, 2'b00);
        tick();
        chk("single read resp c5",  d2_resp,  2'b01);
        chk("single read rdata c5", d2_rdata, 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF);
        chk("single read strobe off c5", d2_l2r, 1'b0);
        tick();
        chk("single read resp pulse ends", d2_resp, 2'b00);
        wait_idle(0, 50);

        // Simultaneous requests and rotation on the 2-port instance
        rst_pulse();
        rq0.delete();
        lat[0] = 1;
        l2_pat[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        tb_addr[0][0] = 16'h0400;
        tb_addr[0][1] = 16'h0500;
        tb_rd[0][0] = 1'b1;
        tb_rd[0][1] = 1'b1;
        wait_idle(0, 60);
        tb_rd[0][0] = 1'b1;
        wait_idle(0, 60);
        tb_rd[0][0] = 1'b1;
        tb_rd[0][1] = 1'b1;
        wait_idle(0, 60);
        chk("rotation count d2", rq0.size(), 5);
        if (rq0.size() == 5)
            for (int i = 0; i < 5; i++) chk($sformatf("rotation d2 grant %0d", i), rq0[i], exp2[i]);

        // Four ports writing continuously
        rst_pulse();
        rq1.delete();
        wq1.delete();
        lat[1] = 1;
        for (int p = 0; p < 4; p++) begin
            tb_addr[1][p]  = 16'h1000 + 16'(p * 16'h40);
            tb_wdata[1][p] = lines[p];
            tb_wr[1][p]    = 1'b1;
            refill[1][p]   = 1'b1;
        end
        for (int c = 0; c < 200 && rq1.size() < 5; c++) tick();
        for (int p = 0; p < 4; p++) refill[1][p] = 1'b0;
        wait_idle(1, 200);
        chk("rotation d4 enough grants", rq1.size() >= 5, 1'b1);
        if (rq1.size() >= 5 && wq1.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("rotation d4 grant %0d", i), rq1[i], exp4[i]);
                chk($sformatf("rotation d4 wdata %0d", i), wq1[i], expw4[i]);
            end
        end

        // Read and write together on one port is a write
        lat[0] = 2;
        tb_addr[0][1]  = 16'h00F0;
        tb_wdata[0][1] = 128'hA5A5_0000_A5A5_0000_A5A5_0000_A5A5_00F0;
        tb_rd[0][1] = 1'b1;
        tb_wr[0][1] = 1'b1;
        tick();
        chk("rw both L2_write", d2_l2w, 1'b1);
        chk("rw both L2_read",  d2_l2r, 1'b0);
        chk("rw both L2_addr",  d2_l2a, 16'h00F0);
        chk("rw both L2_wdata", d2_l2wd, 128'hA5A5_0000_A5A5_0000_A5A5_0000_A5A5_00F0);
        wait_idle(0, 50);

        // Address change while busy does not reach L2
        lat[0] = 4;
        tb_addr[0][1] = 16'h0100;
        tb_rd[0][1]   = 1'b1;
        tick();
        chk("addr hold c1", d2_l2a, 16'h0100);
        tb_addr[0][1] = 16'h0200;
        tick();
        tick();
        chk("addr hold busy", d2_l2a, 16'h0100);
        chk("addr hold strobe", d2_l2r, 1'b1);
        wait_idle(0, 50);

        // Asynchronous reset in the middle of a transaction
        lat[0] = 20;
        tb_addr[0][0] = 16'h0330;
        tb_rd[0][0]   = 1'b1;
        tick();
        tick();
        chk("pre-reset busy", d2_l2r, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset L2_read", d2_l2r, 1'b0);
        chk("async reset L2_addr", d2_l2a, 16'h0);
        chk("async reset resp",    d2_resp, 2'b00);
        tick();
        rst = 1'b0;
        tb_rd[0][0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("post-reset no strobe", d2_l2r | d2_l2w, 1'b0);
        chk("post-reset no resp",   d2_resp, 2'b00);

        // Stray L2 completion while idle is ignored
        l2_resp[0] = 1'b1;
        tick();
        tick();
        chk("stray L2_resp no resp",   d2_resp, 2'b00);
        chk("stray L2_resp no strobe", d2_l2r | d2_l2w, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_rr_arbiter.md
# l2_rr_arbiter

Parametrised round-robin arbiter multiplexing NUM_PORTS L1 cache miss/writeback channels onto the single L2 line interface. Successor to the fixed two-port instruction/data arbiter: any port count, configurable address/line width, fair rotating priority, and registered L2 outputs. Sits between the L1 caches and L2 inside cache_system.

## Interface
- NUM_PORTS, 2: number of requesting L1 channels (≥2).
- ADDR_WIDTH, 16: byte address width.
- LINE_WIDTH, 128: cache line width.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_read  in  NUM_PORTS  per-port line read request, held until that port's resp.
- req_write  in  NUM_PORTS  per-port line write request, held until that port's resp.
- req_addr  in  NUM_PORTS×ADDR_WIDTH  per-port line address.
- req_wdata  in  NUM_PORTS×LINE_WIDTH  per-port write line.
- req_rdata  out  LINE_WIDTH  read line, shared by all ports, valid only in the resp cycle.
- req_resp  out  NUM_PORTS  one-hot completion pulse.
- L2_read  out  1  line read to L2.
- L2_write  out  1  line write to L2.
- L2_addr  out  ADDR_WIDTH  L2 address.
- L2_wdata  out  LINE_WIDTH  L2 write line.
- L2_rdata  in  LINE_WIDTH  L2 read line, valid with L2_resp.
- L2_resp  in  1  L2 completion, one cycle.

## Operation
- FSM: IDLE, BUSY, DONE.
- IDLE: port p active if req_read[p]|req_write[p]. If any active, grant first active port at or after rr_ptr (wrapping modulo NUM_PORTS); capture op, addr, wdata into output registers; grant_idx <= p; go BUSY. None active: stay.
- Both read and write on one port: treated as write.
- BUSY: L2_read/L2_write/L2_addr/L2_wdata held from registers, unaffected by requester inputs. On L2_resp: latch L2_rdata into rdata register; rr_ptr <= (grant_idx+1) mod NUM_PORTS; go DONE.
- DONE: req_resp[grant_idx]=1, all other bits 0; L2_read=L2_write=0; go IDLE unconditionally.
- Requester dropping its request while granted is illegal; the arbiter still completes the L2 transaction and pulses resp.
- L2_resp outside BUSY is ignored.

## Timing
- Reset values: L2_read=0, L2_write=0, L2_addr=0, L2_wdata=0, req_resp=0, req_rdata=0, state IDLE, rr_ptr=0, grant_idx=0.
- Request seen in IDLE at cycle 0 → L2_read/L2_write high from cycle 1.
- L2_resp at cycle k → req_resp pulse at cycle k+1 (exactly one cycle), req_rdata valid same cycle.
- DONE gap guarantees the completed port's request is deasserted before the next IDLE arbitration; minimum spacing between L2 transactions is 2 idle cycles of L2_read/L2_write low... precisely: L2 strobe low in DONE and IDLE, rises again the cycle after IDLE.
- Back-to-back with all ports requesting: grants rotate 0,1,…,NUM_PORTS-1,0.
- rst asserted mid-transaction: all outputs drop immediately, transaction abandoned, rr_ptr=0; L2 must be reset concurrently.

## Structure
- Package arbiter_pkg: state enum (IDLE/BUSY/DONE), default ADDR_WIDTH/LINE_WIDTH constants.
- Sub-module rr_picker: combinational, inputs active vector and rr_ptr, outputs found flag and grant index; parametrised by NUM_PORTS.
- Top: FSM, output registers, rdata register, rr_ptr.

## Test plan
- Reset: rst pulse mid-clock → all outputs 0 immediately, no L2 strobe afterwards with no requests.
- Single read: port 0 reads 0x1230, L2 responds 3 cycles later with 0xDEAD…BEEF → L2_read cycles 1–4, req_resp=2'b01 with that rdata at cycle 5.
- Simultaneous: ports 0 and 1 both request at reset rr_ptr=0 → port 0 served first, port 1 next; then both again → port 0 after port 1 (rotation).
- NUM_PORTS=4, all write continuously → grant order 0,1,2,3,0; L2_wdata matches granted port's line each time.
- Read+write same port, addr 0x00F0 → L2_write=1, L2_read=0.
- Port 1 changes req_addr from 0x0100 to 0x0200 during BUSY → L2_addr stays 0x0100; rst during BUSY → strobes drop, no resp.
